gcd_client: RTL and testbench

- Initiator-side sequencer for the gcd core.
- Accepts operand pairs on a valid/ready request stream and drives the core's start/opa/opb.
- Waits for done, captures the result and returns it on a valid/ready response stream.
- Sits between a host/test-driver stream and the gcd core; one operation is outstanding at a time.

---
 rtl/gcd_pkg.sv | 14 +
 rtl/gcd_client_if.sv | 38 +++
 rtl/gcd_client.sv | 117 +++++++++++
 tb/tb_gcd_client.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the gcd core, its client sequencer and the bench.
package gcd_pkg;

  localparam int GCD_WIDTH          = 32;
  localparam int GCD_TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2,
    S_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/gcd_client_if.sv
// Bundle of the host request/response streams and the gcd core handshake.
// The slave modport is the client sequencer; master is the host plus core side.
interface gcd_client_if
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
);

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_opa;
  logic [WIDTH-1:0] req_opb;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [WIDTH-1:0] rsp_opa;
  logic [WIDTH-1:0] rsp_opb;

  logic             gcd_start;
  logic [WIDTH-1:0] gcd_opa;
  logic [WIDTH-1:0] gcd_opb;
  logic [WIDTH-1:0] gcd_result;
  logic             gcd_done;

  modport slave (
    input  req_valid, req_opa, req_opb, rsp_ready, gcd_result, gcd_done,
    output req_ready, rsp_valid, rsp_result, rsp_opa, rsp_opb,
           gcd_start, gcd_opa, gcd_opb
  );

  modport master (
    output req_valid, req_opa, req_opb, rsp_ready, gcd_result, gcd_done,
    input  req_ready, rsp_valid, rsp_result, rsp_opa, rsp_opb,
           gcd_start, gcd_opa, gcd_opb
  );

endinterface

// File: rtl/gcd_client.sv
// Initiator-side sequencer for the gcd core: one operation outstanding at a time.
// Optional WAIT watchdog and rsp_timeout port enabled by defining GCD_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | ready for a request
// WAIT    | start held to the core, waiting for done
// DRAIN   | result captured, waiting for done to fall
// RESP    | response presented until accepted
module gcd_client
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
`ifdef GCD_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = GCD_TIMEOUT_CYCLES
`endif
) (
  input  logic       clk,
  input  logic       reset,
  gcd_client_if.slave bus,
  output logic       busy
`ifdef GCD_TIMEOUT_EN
  , output logic     rsp_timeout
`endif
);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_oa;
  logic [WIDTH-1:0] r_ob;
  logic [WIDTH-1:0] r_res;
  logic             w_accept;
  logic             w_zero_op;
  logic             w_tmo;

  assign w_accept  = (r_state == S_IDLE) && bus.req_valid;
  assign w_zero_op = (bus.req_opa == '0) || (bus.req_opb == '0);

`ifdef GCD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_tmo_cnt;
  logic             r_timeout;

  // Loaded on accept so the first WAIT cycle starts a fresh TIMEOUT_CYCLES window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmo_cnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_tmo_cnt <= CNT_W'(TIMEOUT_CYCLES - 1);
        r_timeout <= 1'b0;
      end else if ((r_state == S_WAIT) && (r_tmo_cnt != '0)) begin
        r_tmo_cnt <= r_tmo_cnt - 1'b1;
      end
      if (w_tmo) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign w_tmo       = (r_state == S_WAIT) && !bus.gcd_done && (r_tmo_cnt == '0);
  assign rsp_timeout = r_timeout;
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_zero_op ? S_RESP : S_WAIT;
      S_WAIT:  if (bus.gcd_done || w_tmo) w_next = S_DRAIN;
      S_DRAIN: if (!bus.gcd_done) w_next = S_RESP;
      S_RESP:  if (bus.rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // oa|ob is the final answer when either operand is zero; otherwise overwritten from the core.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_oa  <= '0;
      r_ob  <= '0;
      r_res <= '0;
    end else if (w_accept) begin
      r_oa  <= bus.req_opa;
      r_ob  <= bus.req_opb;
      r_res <= bus.req_opa | bus.req_opb;
    end else if ((r_state == S_WAIT) && bus.gcd_done) begin
      r_res <= bus.gcd_result;
    end else if (w_tmo) begin
      r_res <= '0;
    end
  end

  always_comb begin
    bus.req_ready = (r_state == S_IDLE);
    bus.rsp_valid = (r_state == S_RESP);
    bus.gcd_start = (r_state == S_WAIT);
    busy          = (r_state != S_IDLE);
  end

  assign bus.gcd_opa    = r_oa;
  assign bus.gcd_opb    = r_ob;
  assign bus.rsp_opa    = r_oa;
  assign bus.rsp_opb    = r_ob;
  assign bus.rsp_result = r_res;

endmodule

// File: tb/tb_gcd_client.sv
// Scoreboard bench for gcd_client with a behavioural gcd core model.
// Define GCD_TIMEOUT_EN to also exercise the WAIT watchdog.
module tb_gcd_client;
  import gcd_pkg::*;

  localparam int W = GCD_WIDTH;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    bit           tmo;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic busy;
`ifdef GCD_TIMEOUT_EN
  logic rsp_timeout;
`endif

  gcd_client_if #(.WIDTH(W)) bus ();

  gcd_client #(
    .WIDTH(W)
`ifdef GCD_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .busy (busy)
`ifdef GCD_TIMEOUT_EN
    , .rsp_timeout(rsp_timeout)
`endif
  );

  initial forever #5 clk = ~clk;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_starts = 0;
  int   rsp_mode = 0;
  int   lat_min = 0;
  int   lat_max = 4;
  bit   core_mute = 1'b0;
  bit   tmo_exp = 1'b0;

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a_in, input logic [W-1:0] b_in);
    logic [W-1:0] a, b, t;
    a = a_in;
    b = b_in;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_req(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   g;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_opa   = a;
    bus.req_opb   = b;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!bus.req_ready && g < 3000);
    chk("req_accept", bus.req_ready, 1);
    if (!bus.req_ready) begin
      bus.req_valid = 1'b0;
      return;
    end
    e.a   = a;
    e.b   = b;
    e.r   = tmo_exp ? '0 : ref_gcd(a, b);
    e.tmo = tmo_exp;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_opa   = $urandom;
    bus.req_opb   = $urandom;
    @(negedge clk);
    chk("busy_after_accept", busy, 1);
    if (a == 0 || b == 0) begin
      chk("bypass_rsp_latency", bus.rsp_valid, 1);
      chk("bypass_no_start", bus.gcd_start, 0);
    end else begin
      chk("start_latency", bus.gcd_start, 1);
      chk("gcd_opa", bus.gcd_opa, a);
      chk("gcd_opb", bus.gcd_opb, b);
    end
`ifdef GCD_TIMEOUT_EN
    chk("timeout_cleared_on_accept", rsp_timeout, 0);
`endif
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!(sb_q.size() == 0 && bus.req_ready) && g < 3000);
    chk("drain_to_idle", (sb_q.size() == 0 && bus.req_ready), 1);
    chk("idle_busy", busy, 0);
  endtask

  // Core model: fixed-latency-per-op gcd with a multi-cycle done and junk result when idle.
  initial begin : core
    int           phase, cnt, hold;
    logic [W-1:0] res;
    phase = 0; cnt = 0; hold = 0; res = '0;
    bus.gcd_done   = 1'b0;
    bus.gcd_result = '0;
    forever begin
      @(posedge clk or posedge reset); #1;
      if (reset) begin
        phase = 0;
        bus.gcd_done = 1'b0;
      end else begin
        case (phase)
          0: begin
            bus.gcd_result = $urandom;
            if (bus.gcd_start) begin
              n_starts++;
              res   = ref_gcd(bus.gcd_opa, bus.gcd_opb);
              cnt   = $urandom_range(lat_max, lat_min);
              hold  = $urandom_range(3, 1);
              phase = core_mute ? 3 : 1;
            end
          end
          1: begin
            if (cnt == 0) begin
              bus.gcd_done   = 1'b1;
              bus.gcd_result = res;
              phase = 2;
            end else begin
              cnt--;
            end
          end
          2: begin
            if (hold <= 1) begin
              bus.gcd_done   = 1'b0;
              bus.gcd_result = $urandom;
              phase = 0;
            end else begin
              hold--;
            end
          end
          default: if (!bus.gcd_start) phase = 0;
        endcase
      end
    end
  end

  initial begin : rsp_drv
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rsp_mode)
        0:       bus.rsp_ready = 1'b1;
        1:       bus.rsp_ready = 1'($urandom_range(1, 0));
        default: bus.rsp_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on each response handshake and checks stream rules.
  initial begin : mon
    exp_t         e;
    logic         pv, pr, ps, pd;
    logic [W-1:0] p_res, p_opa, p_opb, p_ga, p_gb;
    pv = 0; pr = 0; ps = 0; pd = 0;
    p_res = '0; p_opa = '0; p_opb = '0; p_ga = '0; p_gb = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pv = 0; ps = 0; pd = 0;
      end else begin
        if (bus.rsp_valid && bus.rsp_ready) begin
          if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_rsp: result %0d with nothing outstanding, expected no response", bus.rsp_result);
          end else begin
            e = sb_q.pop_front();
            chk("rsp_result", bus.rsp_result, e.r);
            chk("rsp_opa", bus.rsp_opa, e.a);
            chk("rsp_opb", bus.rsp_opb, e.b);
`ifdef GCD_TIMEOUT_EN
            chk("rsp_timeout", rsp_timeout, W'(e.tmo));
`endif
          end
        end
        if (pv && !pr) begin
          chk("rsp_valid_held", bus.rsp_valid, 1);
          chk("rsp_result_stable", bus.rsp_result, p_res);
          chk("rsp_opa_stable", bus.rsp_opa, p_opa);
          chk("rsp_opb_stable", bus.rsp_opb, p_opb);
        end
        if (bus.rsp_valid) chk("req_ready_low_in_resp", bus.req_ready, 0);
        if (bus.gcd_done) chk("no_rsp_while_done", bus.rsp_valid, 0);
        if (ps && pd) chk("start_drops_after_done", bus.gcd_start, 0);
        if (ps && bus.gcd_start) begin
          chk("gcd_opa_stable", bus.gcd_opa, p_ga);
          chk("gcd_opb_stable", bus.gcd_opb, p_gb);
        end
        pv = bus.rsp_valid; pr = bus.rsp_ready; ps = bus.gcd_start; pd = bus.gcd_done;
        p_res = bus.rsp_result; p_opa = bus.rsp_opa; p_opb = bus.rsp_opb;
        p_ga = bus.gcd_opa; p_gb = bus.gcd_opb;
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int           s;
    int           sel;
    logic [W-1:0] a, b, g;
    bus.req_valid = 1'b0;
    bus.req_opa   = '0;
    bus.req_opb   = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_gcd_start", bus.gcd_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_result", bus.rsp_result, 0);
    chk("rst_gcd_opa", bus.gcd_opa, 0);
    chk("rst_gcd_opb", bus.gcd_opb, 0);
    reset = 1'b0;

    do_req(1071, 462);
    wait_idle();
    do_req(1075, 255);
    wait_idle();

    s = n_starts;
    do_req(0, 48);
    do_req(0, 0);
    wait_idle();
    chk("bypass_core_untouched", n_starts, s);

    rsp_mode = 2;
    do_req(300, 45);
    fork
      do_req(12, 18);
      begin : bp
        int k;
        k = 0;
        while (!bus.rsp_valid && k < 500) begin
          @(negedge clk);
          k++;
        end
        chk("bp_rsp_valid_seen", bus.rsp_valid, 1);
        repeat (10) begin
          @(negedge clk);
          chk("bp_rsp_valid", bus.rsp_valid, 1);
          chk("bp_rsp_result", bus.rsp_result, 15);
          chk("bp_req_blocked", bus.req_ready, 0);
        end
        rsp_mode = 0;
      end
    join
    wait_idle();

    lat_min = 40;
    lat_max = 40;
    do_req(1071, 462);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_gcd_start", bus.gcd_start, 0);
    chk("rst_mid_rsp_valid", bus.rsp_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_req_ready", bus.req_ready, 1);
    sb_q.delete();
    @(negedge clk);
    #2 reset = 1'b0;
    lat_min = 0;
    lat_max = 5;
    do_req(12, 18);
    wait_idle();

    rsp_mode = 1;
    repeat (40) begin
      sel = $urandom_range(9, 0);
      if (sel == 0) begin
        a = '0;
        b = $urandom_range(1000, 0);
      end else if (sel == 1) begin
        a = $urandom_range(1000, 0);
        b = '0;
      end else if (sel == 2) begin
        a = $urandom;
        b = $urandom;
      end else begin
        g = $urandom_range(60, 1);
        a = g * $urandom_range(500, 1);
        b = g * $urandom_range(500, 1);
      end
      do_req(a, b);
    end
    wait_idle();

`ifdef GCD_TIMEOUT_EN
    core_mute = 1'b1;
    tmo_exp   = 1'b1;
    do_req(35, 21);
    wait_idle();
    core_mute = 1'b0;
    tmo_exp   = 1'b0;
    do_req(35, 21);
    wait_idle();
`endif

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
